// File: rtl/imem_loader_if.sv
//------------------------------------------------------------------------------
// imem_loader_if : byte-stream input and instruction-memory write bus of the
//                  program loader.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface imem_loader_if #(
    parameter int ADDR_W = 30
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              restart;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;
    logic [15:0]       words_loaded;

    // Host side: supplies the stream and observes the memory write port.
    modport master (
        output in_valid, in_data, restart,
        input  in_ready, wr_en, wr_addr, wr_data,
        input  cpu_reset, load_done, load_error, words_loaded
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data, restart,
        output in_ready, wr_en, wr_addr, wr_data,
        output cpu_reset, load_done, load_error, words_loaded
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// imem_loader : framed byte-stream loader writing big-endian words to the
//               instruction memory; holds the CPU in reset until verified.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
    parameter int                ADDR_W    = 30,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  wire logic       clock,
    input  wire logic       reset,
    imem_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

    state_t            state_q,     state_d;
    logic [15:0]       count_q,     count_d;
    logic [1:0]        byte_idx_q,  byte_idx_d;
    logic [7:0]        acc_q,       acc_d;
    logic [23:0]       asm_q,       asm_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [31:0]       wr_data_q,   wr_data_d;
    logic [15:0]       words_q,     words_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;
    logic              cpu_rst_q,   cpu_rst_d;

    logic              in_ready_w;
    logic              accept_w;
    logic [15:0]       hdr_count_w;
    logic [15:0]       words_inc_w;

    // in_ready is gated by the reset pin so it drops the instant reset asserts.
    assign in_ready_w  = reset && ((state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                                   (state_q == ST_DATA)   || (state_q == ST_CSUM));
    assign accept_w    = bus.in_valid && in_ready_w;
    assign hdr_count_w = {count_q[15:8], bus.in_data};
    assign words_inc_w = words_q + 16'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HDR_HI;
            count_q    <= '0;
            byte_idx_q <= '0;
            acc_q      <= '0;
            asm_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            words_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            acc_q      <= acc_d;
            asm_q      <= asm_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            words_q    <= words_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        acc_d      = acc_q;
        asm_d      = asm_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        words_d    = words_q;
        done_d     = done_q;
        err_d      = err_q;
        cpu_rst_d  = cpu_rst_q;

        case (state_q)
            ST_HDR_HI: begin
                if (accept_w) begin
                    count_d[15:8] = bus.in_data;
                    acc_d         = acc_q ^ bus.in_data;
                    state_d       = ST_HDR_LO;
                end
            end

            ST_HDR_LO: begin
                if (accept_w) begin
                    count_d[7:0] = bus.in_data;
                    acc_d        = acc_q ^ bus.in_data;
                    if ({1'b0, hdr_count_w} > MAX_WORDS_W) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (hdr_count_w == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (accept_w) begin
                    asm_d      = {asm_q[15:0], bus.in_data};
                    acc_d      = acc_q ^ bus.in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Fourth byte completes the word: write it out next cycle.
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {asm_q, bus.in_data};
                        wr_addr_d = BASE_ADDR + ADDR_W'(words_q);
                        words_d   = words_inc_w;
                        if (words_inc_w == count_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end

            ST_CSUM: begin
                if (accept_w) begin
                    if (bus.in_data == acc_q) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d   = ST_ERR;
                        err_d     = 1'b1;
                    end
                end
            end

            ST_DONE, ST_ERR: begin
                if (bus.restart) begin
                    state_d    = ST_HDR_HI;
                    count_d    = '0;
                    byte_idx_d = '0;
                    acc_d      = '0;
                    words_d    = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_rst_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_HDR_HI;
            end
        endcase
    end

    assign bus.in_ready     = in_ready_w;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.cpu_reset    = cpu_rst_q;
    assign bus.load_done    = done_q;
    assign bus.load_error   = err_q;
    assign bus.words_loaded = words_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// tb_imem_loader : scoreboard bench for imem_loader (default build and a
//                  4-bit address build with BASE_ADDR=15 for wrap-around).
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    imem_loader_if #(.ADDR_W(30)) if0 ();
    imem_loader_if #(.ADDR_W(4))  if1 ();

    imem_loader #(.ADDR_W(30), .BASE_ADDR(30'd0), .MAX_WORDS(1024)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    imem_loader #(.ADDR_W(4), .BASE_ADDR(4'd15), .MAX_WORDS(1024)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] e0, e1;
    logic        prev0 = 1'b0;
    logic        prev1 = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write-port monitors: every strobe pops one expected {addr, data}.
    always @(posedge clock) begin
        #1;
        if (if0.wr_en) begin
            check("wr0_gap", 64'(prev0), 64'd0);
            if (q0.size() == 0) begin
                check("wr0_unexpected", 64'd1, 64'd0);
            end else begin
                e0 = q0.pop_front();
                check("wr0_addr", 64'(if0.wr_addr), 64'(e0[63:32]));
                check("wr0_data", 64'(if0.wr_data), 64'(e0[31:0]));
            end
        end
        prev0 = if0.wr_en;
    end

    always @(posedge clock) begin
        #1;
        if (if1.wr_en) begin
            check("wr1_gap", 64'(prev1), 64'd0);
            if (q1.size() == 0) begin
                check("wr1_unexpected", 64'd1, 64'd0);
            end else begin
                e1 = q1.pop_front();
                check("wr1_addr", 64'(if1.wr_addr), 64'(e1[63:32]));
                check("wr1_data", 64'(if1.wr_data), 64'(e1[31:0]));
            end
        end
        prev1 = if1.wr_en;
    end

    function automatic logic rdy(input int u);
        return (u == 0) ? if0.in_ready : if1.in_ready;
    endfunction

    task automatic drive(input int u, input logic v, input logic [7:0] d);
        if (u == 0) begin
            if0.in_valid = v;
            if0.in_data  = d;
        end else begin
            if1.in_valid = v;
            if1.in_data  = d;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int u, input logic [7:0] b);
        int n;
        n = 0;
        drive(u, 1'b1, b);
        while (!rdy(u) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("ready_timeout", 64'd0, 64'd1);
        @(negedge clock);
        drive(u, 1'b0, 8'h00);
    endtask

    task automatic frame(input int u, input byte_q_t b, input bit gap);
        foreach (b[i]) begin
            send(u, b[i]);
            if (gap) @(negedge clock);
        end
    endtask

    task automatic restart0();
        if0.restart  = 1'b1;
        if0.in_valid = 1'b1;
        if0.in_data  = 8'hAA;
        @(negedge clock);
        if0.restart  = 1'b0;
        if0.in_valid = 1'b0;
        if0.in_data  = 8'h00;
    endtask

    byte_q_t fb;

    initial begin
        if0.in_valid = 1'b0; if0.in_data = 8'h00; if0.restart = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = 8'h00; if1.restart = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_cpu_reset", 64'(if0.cpu_reset),    64'd1);
        check("rst_in_ready",  64'(if0.in_ready),     64'd0);
        check("rst_wr_en",     64'(if0.wr_en),        64'd0);
        check("rst_wr_addr",   64'(if0.wr_addr),      64'd0);
        check("rst_wr_data",   64'(if0.wr_data),      64'd0);
        check("rst_done",      64'(if0.load_done),    64'd0);
        check("rst_error",     64'(if0.load_error),   64'd0);
        check("rst_words",     64'(if0.words_loaded), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("hdr_in_ready",  64'(if0.in_ready),     64'd1);

        // Single word, back to back, with write-latency probe
        q0.push_back({32'd0, 32'h2008_0005});
        send(0, 8'h00); send(0, 8'h01); send(0, 8'h20); send(0, 8'h08); send(0, 8'h00);
        check("w1_no_early_wr", 64'(if0.wr_en), 64'd0);
        send(0, 8'h05);
        check("w1_wr_latency", 64'(if0.wr_en),        64'd1);
        check("w1_words_inc",  64'(if0.words_loaded), 64'd1);
        send(0, 8'h2C);
        check("w1_done",      64'(if0.load_done),    64'd1);
        check("w1_cpu_reset", 64'(if0.cpu_reset),    64'd0);
        check("w1_words",     64'(if0.words_loaded), 64'd1);
        check("w1_in_ready",  64'(if0.in_ready),     64'd0);
        check("w1_q_empty",   64'(q0.size()),        64'd0);

        // Restart with in_valid high: no byte taken, back to HDR_HI
        restart0();
        check("rs_in_ready",  64'(if0.in_ready),     64'd1);
        check("rs_cpu_reset", 64'(if0.cpu_reset),    64'd1);
        check("rs_done",      64'(if0.load_done),    64'd0);
        check("rs_words",     64'(if0.words_loaded), 64'd0);
        check("rs_wr_data_kept", 64'(if0.wr_data),   64'h2008_0005);

        // Throttled three-word frame
        for (int i = 0; i < 3; i++) q0.push_back({32'(i), 32'(i + 1)});
        fb = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
               8'h00, 8'h00, 8'h00, 8'h03, 8'h03};
        frame(0, fb, 1'b1);
        check("thr_done",    64'(if0.load_done),    64'd1);
        check("thr_words",   64'(if0.words_loaded), 64'd3);
        check("thr_q_empty", 64'(q0.size()),        64'd0);

        // Bad checksum
        restart0();
        q0.push_back({32'd0, 32'h2008_0005});
        fb = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        frame(0, fb, 1'b0);
        check("bad_error",     64'(if0.load_error), 64'd1);
        check("bad_cpu_reset", 64'(if0.cpu_reset),  64'd1);
        check("bad_done",      64'(if0.load_done),  64'd0);
        check("bad_in_ready",  64'(if0.in_ready),   64'd0);
        check("bad_q_empty",   64'(q0.size()),      64'd0);

        // Count over the limit: ERR straight after the header
        restart0();
        check("lim_cleared", 64'(if0.load_error), 64'd0);
        fb = '{8'h04, 8'h01};
        frame(0, fb, 1'b0);
        check("lim_error",    64'(if0.load_error),   64'd1);
        check("lim_in_ready", 64'(if0.in_ready),     64'd0);
        check("lim_words",    64'(if0.words_loaded), 64'd0);

        // Empty frame
        restart0();
        fb = '{8'h00, 8'h00, 8'h00};
        frame(0, fb, 1'b0);
        check("empty_done",  64'(if0.load_done),    64'd1);
        check("empty_words", 64'(if0.words_loaded), 64'd0);

        // Reset in the middle of word 0
        restart0();
        fb = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        frame(0, fb, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_cpu_reset", 64'(if0.cpu_reset),    64'd1);
        check("mid_in_ready",  64'(if0.in_ready),     64'd0);
        check("mid_wr_en",     64'(if0.wr_en),        64'd0);
        check("mid_words",     64'(if0.words_loaded), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        q0.push_back({32'd0, 32'h1122_3344});
        fb = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        frame(0, fb, 1'b0);
        check("mid_reload_done", 64'(if0.load_done), 64'd1);
        check("mid_q_empty",     64'(q0.size()),     64'd0);

        // Address wrap: ADDR_W=4, BASE_ADDR=15
        q1.push_back({32'd15, 32'hDEAD_BEEF});
        q1.push_back({32'd0,  32'h0123_4567});
        fb = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h20};
        frame(1, fb, 1'b0);
        check("wrap_done",    64'(if1.load_done),    64'd1);
        check("wrap_words",   64'(if1.words_loaded), 64'd2);
        check("wrap_addr",    64'(if1.wr_addr),      64'd0);
        check("wrap_q_empty", 64'(q1.size()),        64'd0);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that feeds the processor's instruction memory through its write port.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive word addresses, in the same word-address space as the fetch path (PC[31:2]).
- Holds the processor in reset until a complete frame has loaded and its checksum verifies.

Parameters:
- ADDR_W, 30, width of the instruction-memory word address.
- BASE_ADDR, 0, word address of the first loaded instruction.
- MAX_WORDS, 1024, largest word count accepted in a frame header.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  in_data holds a stream byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- restart  input  1  single-cycle request to load a new frame; honoured only in DONE or ERR.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  word address for the write.
- wr_data  output  32  instruction word for the write.
- cpu_reset  output  1  active-high reset to the processor.
- load_done  output  1  frame loaded and checksum matched.
- load_error  output  1  frame rejected.
- words_loaded  output  16  words written so far in the current frame.

Behaviour:
- Byte acceptance: a byte is accepted on a rising edge with in_valid=1 and in_ready=1. in_valid may drop at any time with no effect.
- Frame format, in order:
  - 2-byte word count N, high byte first.
  - N words, 4 bytes each, most-significant byte first.
  - 1 checksum byte, equal to the XOR of every header and data byte.
- Reset (reset=0, asynchronous):
  - State HDR_HI.
  - cpu_reset=1.
  - All other outputs 0: in_ready, wr_en, wr_addr, wr_data, load_done, load_error, words_loaded.
  - Internal count, byte index and XOR accumulator cleared.
- in_ready: 1 in states HDR_HI, HDR_LO, DATA and CSUM, except during reset (where it is 0). 0 in DONE and ERR.
- HDR_HI: on accept, latch count[15:8], XOR byte into accumulator, go to HDR_LO.
- HDR_LO: on accept, latch count[7:0] and XOR into accumulator, then:
  - full count > MAX_WORDS -> ERR;
  - full count = 0 -> CSUM;
  - otherwise -> DATA.
- DATA:
  - Shift accepted bytes into a 32-bit assembly register; each byte is also XORed into the accumulator.
  - On the 4th byte of a word, in the next cycle only: wr_en=1, wr_data = assembled word, wr_addr = BASE_ADDR + words_loaded (pre-increment value).
  - words_loaded increments in that same cycle.
  - After word N's write is issued, go to CSUM.
  - Consequences: write latency is 1 cycle after the last byte's accept edge; back-to-back bytes sustain 1 byte per cycle; wr_en never asserts on two consecutive cycles.
- wr_addr arithmetic: BASE_ADDR + index, truncated modulo 2^ADDR_W (wraps silently).
- wr_addr and wr_data hold their last values when wr_en=0.
- CSUM: on accept, compare the byte against the accumulator.
  - Match -> DONE: load_done=1, cpu_reset=0, next cycle.
  - Mismatch -> ERR: load_error=1, cpu_reset stays 1.
- DONE / ERR:
  - Absorbing states; stream bytes are not accepted.
  - restart=1 -> HDR_HI next cycle, with load_done=0, load_error=0, cpu_reset=1, words_loaded=0, accumulator cleared.
  - wr_addr and wr_data keep their values.
- restart in any other state: ignored.
- Reset mid-frame: immediate abort to reset values; the partially loaded memory contents are not erased.
- cpu_reset: deasserts only on a DONE entry, and reasserts on restart or reset.

Test Plan:
- Single word: stream 00 01 20 08 00 05 2C, back to back, in_valid held 1 ->
  - one cycle with wr_en=1, wr_addr=0, wr_data=0x20080005;
  - then load_done=1, cpu_reset=0, words_loaded=1, in_ready=0.
- Throttled multi-word: N=3, words 0x00000001, 0x00000002, 0x00000003, in_valid toggled every other cycle ->
  - three single-cycle writes at addresses 0, 1, 2 with matching data;
  - no write during idle gaps; load_done=1 after a correct checksum.
- Bad checksum: stream 00 01 20 08 00 05 2D ->
  - the write to address 0 still occurs;
  - load_error=1, cpu_reset stays 1, load_done=0, in_ready=0.
- Limit and empty frames:
  - header 04 01 with MAX_WORDS=1024 -> ERR right after the 2nd byte, no writes;
  - after restart, stream 00 00 00 -> DONE, no writes, words_loaded=0.
- Reset mid-word: assert reset=0 after 2 data bytes of word 0 ->
  - immediately cpu_reset=1, in_ready=0, wr_en=0;
  - after release, a fresh frame loads from address 0 correctly.
- Restart and wrap: in DONE, pulse restart with in_valid=1 ->
  - no byte accepted that cycle; HDR_HI next cycle with cpu_reset=1;
  - with ADDR_W=4, BASE_ADDR=15, N=2, writes go to addresses 15 then 0.
